// File: rtl/multiseg_slave.sv
// multiseg_slave: Avalon-MM register slave for a NUM_DIGITS seven-segment display.
// It drives all digits on a parallel bus and also scans them out as one multiplexed digit.
module multiseg_slave #(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLINK_DIV      = 250,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              slave_address,
  input  logic                    slave_read,
  input  logic                    slave_write,
  input  logic [31:0]             slave_writedata,
  input  logic [3:0]              slave_byteenable,
  output logic [31:0]             slave_readdata,
  output logic [7*NUM_DIGITS-1:0] seg_parallel,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel
);
  localparam int unsigned PW          = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW          = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [3:0]  ADDR_CTRL   = 4'd4;
  localparam logic [3:0]  ADDR_MASK   = 4'd5;
  localparam logic [3:0]  ADDR_STATUS = 4'd6;
  localparam logic [6:0]  SEG_POL     = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  logic [2:0]              ctrl_d, ctrl_q;
  logic [PW-1:0]           pre_d, pre_q;
  logic [3:0]              idx_d, idx_q;
  logic [BW-1:0]           blink_d, blink_q;
  logic                    phase_d, phase_q;
  logic [31:0]             readdata_d, readdata_q;
  logic [7*NUM_DIGITS-1:0] seg_parallel_d, seg_parallel_q;
  logic [6:0]              seg_out_d, seg_out_q;
  logic [NUM_DIGITS-1:0]   digit_sel_d, digit_sel_q;

  logic                    en_c, tick_c, blink_wrap_c;
  logic [31:0]             rdata_c;
  logic [15:0]             mask_all_c;
  logic [6:0]              seg_arr_c   [16];
  logic [7:0]              digit_arr_c [16];
  logic                    unused_c;

  assign en_c     = ctrl_q[0];
  assign unused_c = ^slave_writedata;

  // Per-digit storage, blink mask bit and blank-qualified segment pattern; unused slots padded.
  for (genvar g = 0; g < 16; g++) begin : g_digit
    if (g < NUM_DIGITS) begin : g_on
      localparam int unsigned LANE = g % 4;
      logic [6:0] digit_d, digit_q;
      logic       mask_d, mask_q;
      logic [6:0] seg_c;

      always_comb begin
        digit_d = digit_q;
        mask_d  = mask_q;
        if (slave_write && slave_address == 4'(g / 4) && slave_byteenable[LANE])
          digit_d = slave_writedata[8*LANE +: 7];
        if (slave_write && slave_address == ADDR_MASK && slave_byteenable[g / 8])
          mask_d = slave_writedata[g];
        if (!en_c || (ctrl_q[2] && mask_q && phase_q)) seg_c = SEG_POL;
        else if (ctrl_q[1])                            seg_c = hex7(digit_q[3:0]) ^ SEG_POL;
        else                                           seg_c = digit_q ^ SEG_POL;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          digit_q <= '0;
          mask_q  <= 1'b0;
        end else begin
          digit_q <= digit_d;
          mask_q  <= mask_d;
        end
      end

      assign seg_arr_c[g]             = seg_c;
      assign digit_arr_c[g]           = {1'b0, digit_q};
      assign mask_all_c[g]            = mask_q;
      assign seg_parallel_d[7*g +: 7] = seg_c;
      assign digit_sel_d[g]           = en_c && (idx_q == 4'(g));
    end else begin : g_off
      assign seg_arr_c[g]   = SEG_POL;
      assign digit_arr_c[g] = '0;
      assign mask_all_c[g]  = 1'b0;
    end
  end

  // Register read mux; read data is captured only on a read strobe and otherwise held.
  always_comb begin
    rdata_c = '0;
    case (slave_address)
      4'd0, 4'd1, 4'd2, 4'd3:
        rdata_c = {digit_arr_c[{slave_address[1:0], 2'd3}], digit_arr_c[{slave_address[1:0], 2'd2}],
                   digit_arr_c[{slave_address[1:0], 2'd1}], digit_arr_c[{slave_address[1:0], 2'd0}]};
      ADDR_CTRL:   rdata_c = {29'd0, ctrl_q};
      ADDR_MASK:   rdata_c = {16'd0, mask_all_c};
      ADDR_STATUS: rdata_c = {23'd0, phase_q, 4'd0, idx_q};
      default:     rdata_c = '0;
    endcase
  end

  // Control write, scan prescaler, scan index and blink phase (all held at zero while disabled).
  always_comb begin
    ctrl_d       = ctrl_q;
    pre_d        = '0;
    idx_d        = '0;
    blink_d      = '0;
    phase_d      = 1'b0;
    tick_c       = en_c && (pre_q == PW'(SCAN_DIV - 1));
    blink_wrap_c = (blink_q == BW'(BLINK_DIV - 1));
    if (slave_write && slave_address == ADDR_CTRL && slave_byteenable[0])
      ctrl_d = slave_writedata[2:0];
    if (en_c) begin
      pre_d   = tick_c ? '0 : pre_q + PW'(1);
      idx_d   = idx_q;
      blink_d = blink_q;
      phase_d = phase_q;
      if (tick_c) begin
        idx_d   = (idx_q == 4'(NUM_DIGITS - 1)) ? 4'd0 : idx_q + 4'd1;
        blink_d = blink_wrap_c ? '0 : blink_q + BW'(1);
        if (blink_wrap_c) phase_d = ~phase_q;
      end
    end
    readdata_d = slave_read ? rdata_c : readdata_q;
    seg_out_d  = seg_arr_c[idx_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q         <= '0;
      pre_q          <= '0;
      idx_q          <= '0;
      blink_q        <= '0;
      phase_q        <= 1'b0;
      readdata_q     <= '0;
      seg_parallel_q <= {NUM_DIGITS{SEG_POL}};
      seg_out_q      <= SEG_POL;
      digit_sel_q    <= '0;
    end else begin
      ctrl_q         <= ctrl_d;
      pre_q          <= pre_d;
      idx_q          <= idx_d;
      blink_q        <= blink_d;
      phase_q        <= phase_d;
      readdata_q     <= readdata_d;
      seg_parallel_q <= seg_parallel_d;
      seg_out_q      <= seg_out_d;
      digit_sel_q    <= digit_sel_d;
    end
  end

  assign slave_readdata = readdata_q;
  assign seg_parallel   = seg_parallel_q;
  assign seg_out        = seg_out_q;
  assign digit_sel      = digit_sel_q;
endmodule

// File: tb/tb_multiseg_slave.sv
// Directed bench for multiseg_slave: two instances (4 and 6 digits) share one Avalon bus,
// expected values are hand-computed constants.
module tb_multiseg_slave;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  addr = '0;
  logic        rd_s = 1'b0, wr_s = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;

  logic [31:0] rd_a, rd_b;
  logic [27:0] spar_a;
  logic [41:0] spar_b;
  logic [6:0]  so_a, so_b;
  logic [3:0]  ds_a;
  logic [5:0]  ds_b;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  multiseg_slave #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .SEG_ACTIVE_LOW(1'b1)) u_a (
    .clk(clk), .reset_n(reset_n), .slave_address(addr), .slave_read(rd_s), .slave_write(wr_s),
    .slave_writedata(wdata), .slave_byteenable(be), .slave_readdata(rd_a),
    .seg_parallel(spar_a), .seg_out(so_a), .digit_sel(ds_a));

  multiseg_slave #(.NUM_DIGITS(6), .SCAN_DIV(4), .BLINK_DIV(2), .SEG_ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .reset_n(reset_n), .slave_address(addr), .slave_read(rd_s), .slave_write(wr_s),
    .slave_writedata(wdata), .slave_byteenable(be), .slave_readdata(rd_b),
    .seg_parallel(spar_b), .seg_out(so_b), .digit_sel(ds_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bus tasks start and end on a falling edge; the rising edge in between samples the strobe.
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wdata = d; be = b; wr_s = 1'b1;
    @(negedge clk);
    wr_s = 1'b0; be = '0;
  endtask

  task automatic rd(input logic [3:0] a);
    addr = a; rd_s = 1'b1;
    @(negedge clk);
    rd_s = 1'b0;
  endtask

  task automatic rdwr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wdata = d; be = b; rd_s = 1'b1; wr_s = 1'b1;
    @(negedge clk);
    rd_s = 1'b0; wr_s = 1'b0; be = '0;
  endtask

  logic [6:0] so_exp [4] = '{7'h79, 7'h24, 7'h30, 7'h08};
  logic [3:0] sel_exp;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rd", rd_a, 32'h0);
    check("rst_sel", ds_a, 4'h0);
    check("rst_seg", so_a, 7'h7F);
    check("rst_par_a", spar_a, {28{1'b1}});
    check("rst_par_b", spar_b, {42{1'b1}});
    reset_n = 1'b1;
    @(negedge clk);

    wr(4'd0, 32'h12345678, 4'h5);
    rd(4'd0);
    check("be_rd_a", rd_a, 32'h00340078);
    check("be_rd_b", rd_b, 32'h00340078);
    wr(4'd0, 32'h000000FF, 4'h1);
    rd(4'd0);
    check("bit7_ign", rd_a, 32'h0034007F);

    wr(4'd1, 32'h7F7F7F7F, 4'hF);
    rd(4'd1);
    check("oor_b", rd_b, 32'h00007F7F);
    check("oor_a", rd_a, 32'h0);
    wr(4'd6, 32'hFFFFFFFF, 4'hF);
    rd(4'd6);
    check("status_ro", rd_a, 32'h0);
    rd(4'd7);
    check("unimpl", rd_b, 32'h0);
    wr(4'd5, 32'hFFFFFFFF, 4'h1);
    rd(4'd5);
    check("mask_a", rd_a, 32'h0000000F);
    check("mask_b", rd_b, 32'h0000003F);
    wr(4'd5, 32'h0, 4'hF);

    rdwr(4'd4, 32'h4, 4'hF);
    check("rw_old", rd_a, 32'h0);
    rd(4'd4);
    check("rw_new", rd_a, 32'h4);

    // Hex scan: digits 1,2,3,A
    wr(4'd0, 32'h0A030201, 4'hF);
    wr(4'd4, 32'h3, 4'h1);
    @(negedge clk);
    check("hex_par", spar_a, {7'h08, 7'h30, 7'h24, 7'h79});
    for (int k = 0; k < 5; k++) begin
      sel_exp = 4'b0001 << (k % 4);
      check("scan_sel", ds_a, sel_exp);
      check("scan_seg", so_a, so_exp[k % 4]);
      repeat (4) @(negedge clk);
    end

    // Blink on digit 0
    wr(4'd4, 32'h0, 4'h1);
    wr(4'd5, 32'h1, 4'h1);
    wr(4'd4, 32'h7, 4'h1);
    repeat (4) @(negedge clk);
    check("blink_on", spar_a[6:0], 7'h79);
    rd(4'd6);
    check("blink_st0", rd_a, 32'h001);
    repeat (4) @(negedge clk);
    check("blink_off", spar_a[6:0], 7'h7F);
    check("blink_unmask", spar_a[13:7], 7'h24);
    rd(4'd6);
    check("blink_st1", rd_a, 32'h102);
    repeat (7) @(negedge clk);
    check("blink_on2", spar_a[6:0], 7'h79);
    rd(4'd6);
    check("blink_st2", rd_a, 32'h000);

    // Disable while scan index is 3
    wr(4'd4, 32'h0, 4'h1);
    wr(4'd4, 32'h3, 4'h1);
    repeat (12) @(negedge clk);
    check("dis_sel2", ds_a, 4'b0100);
    wr(4'd4, 32'h0, 4'h1);
    check("dis_sel3", ds_a, 4'b1000);
    @(negedge clk);
    check("dis_sel", ds_a, 4'h0);
    check("dis_seg", so_a, 7'h7F);
    check("dis_par", spar_a, {28{1'b1}});
    rd(4'd6);
    check("dis_st", rd_a, 32'h0);

    // Asynchronous reset during an active scan
    wr(4'd4, 32'h3, 4'h1);
    repeat (6) @(negedge clk);
    rd(4'd0);
    check("pre_rst_rd", rd_a, 32'h0A030201);
    #2 reset_n = 1'b0;
    #1;
    check("arst_sel", ds_a, 4'h0);
    check("arst_seg", so_a, 7'h7F);
    check("arst_par", spar_a, {28{1'b1}});
    check("arst_rd", rd_a, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(4'd0);
    check("post_rst_dig", rd_a, 32'h0);
    rd(4'd4);
    check("post_rst_ctrl", rd_a, 32'h0);
    check("post_rst_sel", ds_a, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
